// File: rtl/universal_shift_register_if.sv
// Purpose: control and data bundle between a button/switch bank and the shift register.
// Latency: none (wires only); all timing lives in the register it connects to.
// Backpressure: none; o_tick is a one-cycle valid strobe with no ready.
interface universal_shift_register_if #(
    parameter int W = 8
);
    logic         i_en;
    logic         i_sin;
    logic [2:0]   i_mode;
    logic [W-1:0] i_load_data;
    logic [W-1:0] o_q;
    logic         o_sout;
    logic         o_tick;

    // Stimulus side: drives the controls, observes the register.
    modport master (
        output i_en, i_sin, i_mode, i_load_data,
        input  o_q, o_sout, o_tick
    );

    // Register side.
    modport slave (
        input  i_en, i_sin, i_mode, i_load_data,
        output o_q, o_sout, o_tick
    );
endinterface

// File: rtl/universal_shift_register.sv
// Purpose: W-bit universal shift register (hold/shift/rotate/load) with tick prescaler;
//          optional BOUNCE ping-pong mode when UNI_SR_BOUNCE_EN is defined.
// Latency: Q/SOUT update on the edge that sees a tick; TICK pulses the following cycle.
// Backpressure: none; LOAD overrides everything except reset and suppresses TICK.
module universal_shift_register #(
    parameter int           W    = 8,
    parameter int           DIV  = 25000000,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic                      i_clk_50m,
    input  logic                      i_rst,
    universal_shift_register_if.slave io_bus
);

    // DIV=1 still needs a one-bit counter; it simply never leaves zero.
    localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROTL = 3'b011;
    localparam logic [2:0] MODE_ROTR = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;

    logic [W-1:0]  r_q;
    logic          r_sout;
    logic          r_tick;
    logic [CW-1:0] r_cnt;
    logic          r_pending;
    logic          r_sin_d;

    logic [W-1:0]  w_q_nxt;
    logic          w_sout_nxt;
    logic          w_tick_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_pending_nxt;

    logic          w_load;
    logic          w_tick;
    logic          w_rise;
    logic          w_bit_in;

`ifdef UNI_SR_BOUNCE_EN
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    dir_t r_dir;
    dir_t w_dir_nxt;
`endif

    assign w_load   = (io_bus.i_mode == MODE_LOAD);
    assign w_tick   = io_bus.i_en && (r_cnt == CNT_LAST);
    assign w_rise   = io_bus.i_sin && !r_sin_d;
    // A rising edge in the tick cycle itself is carried by the SIN level.
    assign w_bit_in = r_pending | io_bus.i_sin;

    // Next-state: LOAD wins, otherwise the prescaler decides whether MODE acts this cycle.
    always_comb begin
        w_q_nxt       = r_q;
        w_sout_nxt    = r_sout;
        w_tick_nxt    = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending | w_rise;
`ifdef UNI_SR_BOUNCE_EN
        w_dir_nxt     = r_dir;
`endif
        if (w_load) begin
            w_q_nxt       = io_bus.i_load_data;
            w_cnt_nxt     = '0;
            w_pending_nxt = 1'b0;
            w_sout_nxt    = 1'b0;
`ifdef UNI_SR_BOUNCE_EN
            w_dir_nxt     = DIR_LEFT;
`endif
        end else if (io_bus.i_en) begin
            if (w_tick) begin
                w_cnt_nxt     = '0;
                w_tick_nxt    = 1'b1;
                w_pending_nxt = 1'b0;
                case (io_bus.i_mode)
                    MODE_SHL: begin
                        w_q_nxt    = {r_q[W-2:0], w_bit_in};
                        w_sout_nxt = r_q[W-1];
                    end
                    MODE_SHR: begin
                        w_q_nxt    = {w_bit_in, r_q[W-1:1]};
                        w_sout_nxt = r_q[0];
                    end
                    MODE_ROTL: begin
                        w_q_nxt    = {r_q[W-2:0], r_q[W-1] | w_bit_in};
                        w_sout_nxt = r_q[W-1];
                    end
                    MODE_ROTR: begin
                        w_q_nxt    = {r_q[0] | w_bit_in, r_q[W-1:1]};
                        w_sout_nxt = r_q[0];
                    end
`ifdef UNI_SR_BOUNCE_EN
                    3'b110, 3'b111: begin
                        // Ping-pong a single lit bit; an empty register is reseeded at bit 0.
                        if (r_q == '0) begin
                            w_q_nxt   = {{(W-1){1'b0}}, 1'b1};
                            w_dir_nxt = DIR_LEFT;
                        end else if (r_dir == DIR_LEFT) begin
                            if (r_q[W-1]) begin
                                w_dir_nxt = DIR_RIGHT;
                                w_q_nxt   = {1'b0, r_q[W-1:1]};
                            end else begin
                                w_q_nxt   = {r_q[W-2:0], 1'b0};
                            end
                        end else begin
                            if (r_q[0]) begin
                                w_dir_nxt = DIR_LEFT;
                                w_q_nxt   = {r_q[W-2:0], 1'b0};
                            end else begin
                                w_q_nxt   = {1'b0, r_q[W-1:1]};
                            end
                        end
                    end
`endif
                    default: begin
                        // HOLD (and 11x without BOUNCE): Q and SOUT stay, TICK still pulses.
                        w_q_nxt = r_q;
                    end
                endcase
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    // State registers; reset has priority over LOAD and the prescaler.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_q       <= INIT;
            r_sout    <= 1'b0;
            r_tick    <= 1'b0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_sin_d   <= 1'b0;
        end else begin
            r_q       <= w_q_nxt;
            r_sout    <= w_sout_nxt;
            r_tick    <= w_tick_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_sin_d   <= io_bus.i_sin;
        end
    end

`ifdef UNI_SR_BOUNCE_EN
    // Bounce direction register.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_dir <= DIR_LEFT;
        end else begin
            r_dir <= w_dir_nxt;
        end
    end
`endif

    assign io_bus.o_q    = r_q;
    assign io_bus.o_sout = r_sout;
    assign io_bus.o_tick = r_tick;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: W=8, DIV=4, INIT=0.
// Expected {Q,SOUT} per tick are queued by the stimulus; a monitor pops them on each TICK.
module tb_universal_shift_register;

    typedef struct packed {
        logic [7:0] q;
        logic       sout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    universal_shift_register_if #(.W(8)) bus ();

    universal_shift_register #(
        .W    (8),
        .DIV  (4),
        .INIT (8'h00)
    ) dut (
        .i_clk_50m (clk),
        .i_rst     (rst),
        .io_bus    (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   n_ticks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] q, input logic sout);
        exp_t e;
        e.q    = q;
        e.sout = sout;
        sb_q.push_back(e);
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every TICK must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_tick === 1'b1) begin
            n_ticks++;
            if (sb_q.size() == 0) begin
                chk("unexpected_tick", 32'(bus.o_q), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("tick_q", 32'(bus.o_q), 32'(e.q));
                chk("tick_sout", 32'(bus.o_sout), 32'(e.sout));
            end
        end
    end

    initial begin
        bus.i_en        = 1'b0;
        bus.i_sin       = 1'b0;
        bus.i_mode      = 3'b000;
        bus.i_load_data = 8'h00;

        // Reset for two edges.
        clk_n(2);
        @(negedge clk);
        chk("reset_q", 32'(bus.o_q), 32'h00);
        chk("reset_sout", 32'(bus.o_sout), 32'h0);
        chk("reset_tick", 32'(bus.o_tick), 32'h0);

        // SHL with a one-cycle SIN pulse in the first period.
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        rst      = 1'b0;
        bus.i_en   = 1'b1;
        bus.i_mode = 3'b001;
        clk_n(1);
        bus.i_sin = 1'b1;
        clk_n(1);
        bus.i_sin = 1'b0;
        clk_n(2);
        chk("ticks_before_first", 32'(n_ticks), 32'd0);
        clk_n(1);
        chk("ticks_first", 32'(n_ticks), 32'd1);
        clk_n(3);
        chk("ticks_period_gap", 32'(n_ticks), 32'd1);
        clk_n(1);
        chk("ticks_second", 32'(n_ticks), 32'd2);

        // LOAD tracks LOAD_DATA while held, then ROTL.
        bus.i_mode      = 3'b101;
        bus.i_load_data = 8'h55;
        clk_n(1);
        @(negedge clk);
        chk("load_q_first", 32'(bus.o_q), 32'h55);
        chk("load_no_tick", 32'(bus.o_tick), 32'h0);
        bus.i_load_data = 8'h81;
        clk_n(1);
        bus.i_mode = 3'b011;
        push(8'h03, 1'b1);
        push(8'h06, 1'b0);
        @(negedge clk);
        chk("load_q_track", 32'(bus.o_q), 32'h81);
        clk_n(8);

        // SHR from 01; then a SIN edge in the tick cycle, then pending must be clear.
        bus.i_mode      = 3'b101;
        bus.i_load_data = 8'h01;
        push(8'h00, 1'b1);
        push(8'h80, 1'b0);
        push(8'h40, 1'b0);
        clk_n(1);
        bus.i_mode = 3'b010;
        clk_n(7);
        bus.i_sin = 1'b1;
        clk_n(1);
        bus.i_sin = 1'b0;
        clk_n(4);
        chk("ticks_after_shr", 32'(n_ticks), 32'd6);

        // EN=0 for 10 cycles two cycles into a period.
        push(8'h20, 1'b0);
        clk_n(2);
        bus.i_en = 1'b0;
        clk_n(10);
        chk("freeze_no_tick", 32'(n_ticks), 32'd7);
        chk("freeze_q", 32'(bus.o_q), 32'h40);
        bus.i_en = 1'b1;
        clk_n(2);
        chk("resume_not_early", 32'(n_ticks), 32'd7);
        clk_n(1);
        chk("resume_tick", 32'(n_ticks), 32'd8);

        // Leave a pending bit, then reset mid-period.
        bus.i_sin = 1'b1;
        clk_n(1);
        bus.i_sin = 1'b0;
        rst       = 1'b1;
        clk_n(1);
        @(negedge clk);
        chk("midreset_q", 32'(bus.o_q), 32'h00);
        chk("midreset_sout", 32'(bus.o_sout), 32'h0);
        chk("midreset_tick", 32'(bus.o_tick), 32'h0);
        rst = 1'b0;
        push(8'h00, 1'b0);
        clk_n(4);
        chk("postreset_not_early", 32'(n_ticks), 32'd8);
        clk_n(1);
        chk("postreset_tick", 32'(n_ticks), 32'd9);

        // LOAD 0, then BOUNCE for 16 ticks.
        bus.i_mode      = 3'b101;
        bus.i_load_data = 8'h00;
`ifdef UNI_SR_BOUNCE_EN
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h04, 1'b0); push(8'h08, 1'b0);
        push(8'h10, 1'b0); push(8'h20, 1'b0); push(8'h40, 1'b0); push(8'h80, 1'b0);
        push(8'h40, 1'b0); push(8'h20, 1'b0); push(8'h10, 1'b0); push(8'h08, 1'b0);
        push(8'h04, 1'b0); push(8'h02, 1'b0); push(8'h01, 1'b0); push(8'h02, 1'b0);
`else
        for (int i = 0; i < 16; i++) push(8'h00, 1'b0);
`endif
        clk_n(1);
        bus.i_mode = 3'b110;
        clk_n(65);
        chk("bounce_tick_count", 32'(n_ticks), 32'd25);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
